right_shift_32_seq: RTL and testbench

Multi-cycle 32-bit right shifter, the counterpart of the existing combinational left barrel shifter. It serves the ALU's SRL/SRA path when a registered, handshaked result is preferred over a deep mux tree. The block resolves one select bit per clock (shift by 1, 2, 4, 8, 16) over a single 32-bit working register. It supports logical (zero-fill) and arithmetic (sign-fill) modes.

---
 rtl/right_shift_32_seq_if.sv | 45 ++++
 rtl/right_shift_32_seq.sv | 117 +++++++++++
 tb/tb_right_shift_32_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/right_shift_32_seq_if.sv
// Handshake and data bundle for the multi-cycle right shifter.
//
// Handshake: the requester raises start together with data/select/arith.
// The request is taken on a rising edge where busy is low; while busy is
// high, start and the operand lines are ignored, not queued. Completion is
// marked by a one-cycle done pulse, and res carries the new result in that
// same cycle. res then holds until the next completion.
interface right_shift_32_seq_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] select;
    logic             arith;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic             done;
    // Debug view of the control FSM: 0 = idle, 1 = shifting.
    logic             state_dbg;

    // Requester side.
    modport master (
        output start,
        output data,
        output select,
        output arith,
        input  res,
        input  busy,
        input  done,
        input  state_dbg
    );

    // Shifter side.
    modport slave (
        input  start,
        input  data,
        input  select,
        input  arith,
        output res,
        output busy,
        output done,
        output state_dbg
    );
endinterface

// File: rtl/right_shift_32_seq.sv
// Multi-cycle right shifter (logical or arithmetic).
// Each clock resolves one bit of the shift amount, least significant first,
// by shifting the working register by 1, 2, 4, 8, ... positions. Latency is
// always SEL_W cycles from acceptance to done, whatever the shift amount.
// res, busy and done come straight from flops.
module right_shift_32_seq #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    right_shift_32_seq_if.slave   bus
);

    // The stage counter must be able to hold SEL_W-1.
    localparam int STG_W = (SEL_W > 1) ? $clog2(SEL_W) : 1;
    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [STG_W-1:0] LAST_STG  = STG_W'(SEL_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] w_q,     w_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             fill_q,  fill_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Working register after applying the current stage (1 << stage_q).
    logic [WIDTH-1:0] w_shifted;

    // One stage of the right shift: shift by 2**stage if that select bit is
    // set, filling the vacated top bits with the captured fill bit.
    always_comb begin
        w_shifted = w_q;
        for (int s = 0; s < SEL_W; s++) begin
            if ((stage_q == STG_W'(s)) && sel_q[s]) begin
                w_shifted = (w_q >> (2 ** s)) |
                            (fill_q ? ~(ONES >> (2 ** s)) : '0);
            end
        end
    end

    // Next-state and datapath control: accept in IDLE, step in SHIFT.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        sel_d   = sel_q;
        fill_d  = fill_q;
        stage_d = stage_q;
        res_d   = res_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    w_d     = bus.data;
                    sel_d   = bus.select;
                    // Logical mode always fills with zero.
                    fill_d  = bus.arith & bus.data[WIDTH-1];
                    stage_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_d     = w_shifted;
                stage_d = stage_q + STG_W'(1);
                if (stage_q == LAST_STG) begin
                    // Final stage: publish the result and pulse done.
                    res_d   = w_shifted;
                    done_d  = 1'b1;
                    stage_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            sel_q   <= '0;
            fill_q  <= 1'b0;
            stage_q <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            sel_q   <= sel_d;
            fill_q  <= fill_d;
            stage_q <= stage_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.res       = res_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_right_shift_32_seq.sv
// Self-checking bench for right_shift_32_seq.
module tb_right_shift_32_seq;

    localparam int WIDTH = 32;
    localparam int SEL_W = 5;
    localparam int LAT   = 5;

    logic clk;
    logic reset_n;

    right_shift_32_seq_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    right_shift_32_seq #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain shift operators on the operand.
    function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                              input logic [4:0] s,
                                              input logic a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return sd >>> s;
        return d >> s;
    endfunction

    // ---------------- scoreboard / cycle model ----------------
    // Model: an accepted request completes exactly LAT edges later.
    logic [31:0] exp_q[$];
    int          model_cnt  = 0;
    logic        model_done = 1'b0;
    logic [31:0] model_res  = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            model_cnt  = 0;
            model_done = 1'b0;
            model_res  = '0;
            exp_q.delete();
        end else begin
            check_eq("mon_busy", {31'd0, bus.busy}, {31'd0, model_cnt > 0});
            check_eq("mon_done", {31'd0, bus.done}, {31'd0, model_done});
            check_eq("mon_res", bus.res, model_res);
            // Predict the effect of the coming rising edge.
            model_done = 1'b0;
            if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    if (exp_q.size() > 0) model_res = exp_q.pop_front();
                end
            end else if (bus.start) begin
                model_cnt = LAT;
                exp_q.push_back(ref_shift(bus.data, bus.select, bus.arith));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            step();
            n++;
        end
        check_eq("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [4:0] rand_sel();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'd31;
        return 5'($urandom_range(0, 31));
    endfunction

    // One directed operation with latency and literal result checks.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp,
                          input string tag);
        int lat;
        step();
        wait_idle();
        bus.start  = 1'b1;
        bus.data   = d;
        bus.select = s;
        bus.arith  = a;
        step();
        bus.start  = 1'b0;
        bus.data   = $urandom;
        bus.select = 5'($urandom);
        bus.arith  = 1'($urandom);
        lat = 0;
        while (!bus.done && lat < 20) begin
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, LAT);
        check_eq(tag, bus.res, exp);
        step();
        check_eq({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int early;
        int dones;
        int last_done;
        int cyc;

        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.data   = '0;
        bus.select = '0;
        bus.arith  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_res", bus.res, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // Directed operations.
        run_op(32'hF000_0001, 5'd4,  1'b0, 32'h0F00_0000, "lsr4");
        run_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "asr31");
        run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "lsr31");
        run_op(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, "sel0");
        run_op(32'h1234_5678, 5'b10101, 1'b0, 32'h0000_0091, "lsr21");
        run_op(32'h7000_00F0, 5'd4,  1'b1, 32'h0700_000F, "asr_pos");
        run_op(32'hC000_0000, 5'd1,  1'b1, 32'hE000_0000, "asr1_neg");

        // Reset in the middle of an operation.
        step();
        bus.start  = 1'b1;
        bus.data   = 32'hDEAD_BEEF;
        bus.select = 5'd3;
        bus.arith  = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        check_eq("midrst_res", bus.res, 32'd0);
        check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("midrst_done", {31'd0, bus.done}, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done) dones++;
        end
        check_eq("midrst_nodone", dones, 0);
        run_op(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF, "after_rst");

        // Start while busy is ignored.
        step();
        bus.start  = 1'b1;
        bus.data   = 32'h8765_4321;
        bus.select = 5'd8;
        bus.arith  = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.start  = 1'b1;
        bus.data   = 32'hFFFF_FFFF;
        bus.select = 5'd0;
        bus.arith  = 1'b0;
        step();
        bus.start = 1'b0;
        lat = 2;
        early = 0;
        while (!bus.done && lat < 20) begin
            if (!bus.busy) early++;
            step();
            lat++;
        end
        check_eq("ign_lat", lat, LAT);
        check_eq("ign_busy", early, 0);
        check_eq("ign_res", bus.res, 32'hFF87_6543);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done) dones++;
        end
        check_eq("ign_one_done", dones, 0);

        // Back-to-back with start held high: 1000 random operations.
        wait_idle();
        bus.start = 1'b1;
        dones = 0;
        last_done = -1;
        cyc = 0;
        while (dones < 1000 && cyc < 8000) begin
            bus.data   = $urandom;
            bus.select = rand_sel();
            bus.arith  = 1'($urandom);
            step();
            cyc++;
            if (bus.done) begin
                if (last_done >= 0) check_eq("b2b_gap", cyc - last_done, 6);
                last_done = cyc;
                dones++;
            end
        end
        check_eq("b2b_count", dones, 1000);
        bus.start = 1'b0;

        // Sporadic random requests.
        for (int i = 0; i < 2000; i++) begin
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.data   = $urandom;
            bus.select = rand_sel();
            bus.arith  = 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (10) step();
        check_eq("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
